// File: rtl/mxu_stream_multiplier.sv
// ---------------------------------------------------------------------------
// mxu_stream_multiplier
//   Streaming DIM x DIM matrix multiplier: Y = A*B, or Y = Y_prev + A*B when
//   acc_en is set at accept. One rank-1 (outer-product) update per cycle, so a
//   result is ready DIM cycles after the operands are accepted.
//
// Ports
//   clk        clock, all state on posedge
//   reset_n    synchronous active-low reset
//   in0, in1   matrices A and B, packed [row][col][WIDTH]
//   acc_en     sampled at accept: seed accumulator with current out
//   in_valid   producer has an operand pair
//   in_ready   block is idle and will accept at the next edge
//   out        result Y, packed [row][col][OUT_WIDTH]; held after handshake
//   out_valid  out holds a completed result
//   out_ready  consumer takes the result
//   finished   one-cycle pulse on the first out_valid cycle
// ---------------------------------------------------------------------------

// One accumulator lane: acc_out = acc_in + ext(a) * ext(b), modulo 2^OUT_WIDTH.
module mxu_mac_cell #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 32,
  parameter bit SIGNED    = 1'b0
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [OUT_WIDTH-1:0] acc_in,
  output logic [OUT_WIDTH-1:0] acc_out
);
  logic [OUT_WIDTH-1:0] a_ext;
  logic [OUT_WIDTH-1:0] b_ext;

  // Fill the upper bits with the sign bit (signed) or zero (unsigned), then
  // overlay the element. The low OUT_WIDTH bits of an unsigned product equal
  // those of the signed product, so one multiplier serves both modes.
  always_comb begin
    a_ext              = {OUT_WIDTH{SIGNED && a[WIDTH-1]}};
    a_ext[WIDTH-1:0]   = a;
    b_ext              = {OUT_WIDTH{SIGNED && b[WIDTH-1]}};
    b_ext[WIDTH-1:0]   = b;
    acc_out            = acc_in + a_ext * b_ext;
  end
endmodule

module mxu_stream_multiplier #(
  parameter int DIM       = 4,
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 32,
  parameter bit SIGNED    = 1'b0
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]        in0,
  input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]        in1,
  input  logic                                      acc_en,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  output logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0]    out,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      finished
);
  localparam int KW = $clog2(DIM);
  localparam logic [KW-1:0] K_LAST = KW'(DIM - 1);

  typedef logic [DIM-1:0][DIM-1:0][WIDTH-1:0]     mat_in_t;
  typedef logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0] mat_out_t;
  typedef enum logic [1:0] {ST_IDLE, ST_COMPUTE, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  mat_in_t         a_q, a_d;
  mat_in_t         b_q, b_d;
  mat_out_t        acc_q, acc_d;
  mat_out_t        out_q, out_d;
  logic            fin_q, fin_d;
  mat_out_t        acc_step;

  // Rank-1 update array: cell [r][c] consumes column k of A and row k of B.
  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      mxu_mac_cell #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SIGNED    (SIGNED)
      ) u_cell (
        .a       (a_q[r][k_q]),
        .b       (b_q[k_q][c]),
        .acc_in  (acc_q[r][c]),
        .acc_out (acc_step[r][c])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    fin_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in0;
          b_d     = in1;
          // out still holds the previous result, which is the Y_prev seed.
          acc_d   = acc_en ? out_q : '0;
          k_d     = '0;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        acc_d = acc_step;
        k_d   = k_q + KW'(1);
        if (k_q == K_LAST) begin
          out_d   = acc_step;
          k_d     = '0;
          fin_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      fin_q   <= fin_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign finished  = fin_q;
  assign out       = out_q;

endmodule

// File: tb/tb_mxu_stream_multiplier.sv
// ---------------------------------------------------------------------------
// tb_mxu_stream_multiplier
//   Three configurations share one stimulus stream: unsigned/32-bit,
//   signed/32-bit and unsigned/16-bit outputs. Expected results come from a
//   plain-arithmetic matrix model that tracks each instance's previous result.
// ---------------------------------------------------------------------------
module tb_mxu_stream_multiplier;
  typedef logic [3:0][3:0][7:0]  mat_t;
  typedef logic [3:0][3:0][31:0] mat32_t;
  typedef logic [3:0][3:0][15:0] mat16_t;

  logic   clk;
  logic   reset_n;
  mat_t   in0, in1;
  logic   acc_en, in_valid, out_ready;
  logic   rdy_u, rdy_s, rdy_w;
  logic   vld_u, vld_s, vld_w;
  logic   fin_u, fin_s, fin_w;
  mat32_t out_u, out_s;
  mat16_t out_w;

  int n_tests = 0;
  int n_fail  = 0;
  logic [511:0] prev_u, prev_s, prev_w;

  mxu_stream_multiplier #(.DIM(4), .WIDTH(8), .OUT_WIDTH(32), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .reset_n(reset_n), .in0(in0), .in1(in1), .acc_en(acc_en),
    .in_valid(in_valid), .in_ready(rdy_u), .out(out_u), .out_valid(vld_u),
    .out_ready(out_ready), .finished(fin_u));
  mxu_stream_multiplier #(.DIM(4), .WIDTH(8), .OUT_WIDTH(32), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .in0(in0), .in1(in1), .acc_en(acc_en),
    .in_valid(in_valid), .in_ready(rdy_s), .out(out_s), .out_valid(vld_s),
    .out_ready(out_ready), .finished(fin_s));
  mxu_stream_multiplier #(.DIM(4), .WIDTH(8), .OUT_WIDTH(16), .SIGNED(1'b0)) u_dut_w (
    .clk(clk), .reset_n(reset_n), .in0(in0), .in1(in1), .acc_en(acc_en),
    .in_valid(in_valid), .in_ready(rdy_w), .out(out_w), .out_valid(vld_w),
    .out_ready(out_ready), .finished(fin_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint ext(input logic [7:0] v, input bit sgn);
    return sgn ? longint'($signed(v)) : longint'(v);
  endfunction

  // Y[r][c] = (acc ? Yprev[r][c] : 0) + sum_k A[r][k]*B[k][c], mod 2^ow,
  // packed at element offset (4r+c)*ow.
  function automatic logic [511:0] model(input mat_t a, input mat_t b, input logic acc,
                                         input logic [511:0] prev, input int ow, input bit sgn);
    logic [511:0] res, mask;
    longint sum;
    int idx;
    res  = '0;
    mask = (512'(1) << ow) - 512'(1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        idx = (r * 4 + c) * ow;
        sum = acc ? longint'(((prev >> idx) & mask)) : 64'sd0;
        for (int k = 0; k < 4; k++) sum += ext(a[r][k], sgn) * ext(b[k][c], sgn);
        res |= (512'(sum) & mask) << idx;
      end
    return res;
  endfunction

  function automatic logic [8:0] status();
    return {rdy_u, vld_u, fin_u, rdy_s, vld_s, fin_s, rdy_w, vld_w, fin_w};
  endfunction

  function automatic logic [8:0] st3(input logic [2:0] p);
    return {p, p, p};
  endfunction

  task automatic chk_out(input string tag);
    chk({tag, "_u"}, 512'(out_u), prev_u);
    chk({tag, "_s"}, 512'(out_s), prev_s);
    chk({tag, "_w"}, 512'(out_w), prev_w);
  endtask

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = 8'($urandom);
    return m;
  endfunction

  function automatic mat_t fill(input logic [7:0] v);
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = v;
    return m;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = (r == c) ? 8'd1 : 8'd0;
    return m;
  endfunction

  // Called at a negedge with the DUTs idle; returns at the negedge right after
  // the output handshake edge. stall=1 presents a new pair while in DONE.
  task automatic run_op(input mat_t a, input mat_t b, input logic acc, input int hold,
                        input bit stall);
    int waits;
    prev_u = model(a, b, acc, prev_u, 32, 1'b0);
    prev_s = model(a, b, acc, prev_s, 32, 1'b1);
    prev_w = model(a, b, acc, prev_w, 16, 1'b0);
    in0 = a; in1 = b; acc_en = acc; in_valid = 1'b1; out_ready = 1'b0;
    waits = 0;
    while (!(rdy_u && rdy_s && rdy_w) && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("accept_wait", 512'(waits), 512'(0));
    if (waits >= 20) begin
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Post-accept input changes must not disturb the result in flight.
    in_valid = 1'b0; in0 = rand_mat(); in1 = rand_mat(); acc_en = ~acc;
    for (int i = 0; i < 4; i++) begin
      chk("busy_status", 512'(status()), 512'(st3(3'b000)));
      @(negedge clk);
    end
    chk("done_status", 512'(status()), 512'(st3(3'b011)));
    chk_out("result");
    for (int h = 0; h < hold; h++) begin
      if (stall) begin in_valid = 1'b1; in0 = rand_mat(); in1 = rand_mat(); end
      @(negedge clk);
      chk("hold_status", 512'(status()), 512'(st3(3'b010)));
      chk_out("hold_out");
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_status", 512'(status()), 512'(st3(3'b100)));
    chk_out("post_hs_out");
  endtask

  initial begin
    mat_t a, b;
    reset_n = 1'b0; in0 = '0; in1 = '0; acc_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    prev_u = '0; prev_s = '0; prev_w = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("reset_status", 512'(status()), 512'(st3(3'b100)));
    chk_out("reset_out");

    // Identity times B returns B.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r][c] = 8'(4 * r + c);
    run_op(ident(), b, 1'b0, 0, 1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) chk("t1_eq_b", 512'(out_u[r][c]), 512'(b[r][c]));

    // Signedness: 0xFF * 0xFE.
    run_op(fill(8'hFF), fill(8'hFE), 1'b0, 0, 1'b0);
    chk("t2_signed", 512'(out_s[2][1]), 512'(32'd8));
    chk("t2_unsigned", 512'(out_u[1][3]), 512'(32'd259080));

    // Accumulate chain.
    run_op(ident(), ident(), 1'b0, 0, 1'b0);
    run_op(ident(), ident(), 1'b1, 0, 1'b0);
    chk("t3_acc_diag", 512'(out_u[3][3]), 512'(32'd2));
    chk("t3_acc_off", 512'(out_u[0][1]), 512'(32'd0));
    run_op(ident(), ident(), 1'b0, 0, 1'b0);
    chk("t3_restart", 512'(out_u[2][2]), 512'(32'd1));

    // Backpressure with a stalled producer, then back-to-back accept.
    run_op(rand_mat(), rand_mat(), 1'b0, 10, 1'b1);
    run_op(rand_mat(), rand_mat(), 1'b1, 2, 1'b0);

    // 16-bit wrap.
    run_op(fill(8'hFF), fill(8'hFF), 1'b0, 0, 1'b0);
    chk("t5_wrap", 512'(out_w[0][0]), 512'(16'd63492));

    // Reset while k = 2.
    a = rand_mat(); b = rand_mat();
    in0 = a; in1 = b; acc_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    prev_u = '0; prev_s = '0; prev_w = '0;
    chk("t6_rst_status", 512'(status()), 512'(st3(3'b100)));
    chk_out("t6_rst_out");
    run_op(a, b, 1'b1, 1, 1'b0);

    // Randomized stream.
    for (int i = 0; i < 24; i++)
      run_op(rand_mat(), rand_mat(), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
